charge_entry_ctrl: RTL and testbench
====================================

Name: charge_entry_ctrl

Overview:
- Sits directly downstream of keyMatrix, on the same CLK domain.
- Turns keyMatrix key events (startSet, num, start, clear, enter) into a multi-digit BCD recharge amount.
- Holds a live digit buffer for the display stage.
- On enter, latches the amount and hands it to the balance logic with a one-cycle valid pulse.

Parameters:
- DIGITS, 4, maximum number of BCD digits in the buffer.
- TIMEOUT_CYC, 1000000, idle CLK cycles allowed in ENTRY before the entry is abandoned.
- CNT_W, 20, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- CLK  in  1  system clock.
- RST_n  in  1  asynchronous active-low reset.
- startSet  in  1  from keyMatrix; high while a debounced key is held.
- num  in  5  from keyMatrix; key code, valid while startSet is high.
- start  in  1  from keyMatrix; level, start key held.
- clear  in  1  from keyMatrix; level, clear key held.
- enter  in  1  from keyMatrix; level, enter key held.
- digits  out  4*DIGITS  live BCD buffer; least-significant digit in [3:0].
- digit_cnt  out  $clog2(DIGITS+1)  number of digits entered.
- amount  out  4*DIGITS  amount latched on enter.
- amount_valid  out  1  one-cycle pulse when amount updates.
- busy  out  1  high in ENTRY.
- full  out  1  high when digit_cnt == DIGITS.
- timeout  out  1  one-cycle pulse on entry abandon.

Behaviour:
- Reset: all outputs 0, state IDLE, edge registers 0, timeout counter 0.
- Edge detect: one register stage per level input. An event is a 0->1 transition and is seen the cycle after the input rises. State and outputs update on the next CLK edge, so the effect appears 2 cycles after the input rises.
- Events:
  - Digit event: startSet rises with num <= 9.
  - start/clear/enter events: rising edge of the respective input.
  - num values 10..31 on startSet are ignored unless the optional feature applies.
- State IDLE:
  - start event -> ENTRY; digits=0, digit_cnt=0, counter=0.
  - All other events are ignored.
- State ENTRY (busy=1). Priority when several events share a cycle: clear > enter > digit.
  - clear: digits=0, digit_cnt=0, counter=0; stay in ENTRY.
  - enter with digit_cnt>0: amount<=digits, amount_valid=1 for one cycle, go DONE.
  - enter with digit_cnt==0: ignored; counter still resets.
  - digit with digit_cnt<DIGITS: digits <= {digits[4*DIGITS-5:0], num[3:0]}; digit_cnt+1.
  - digit with digit_cnt==DIGITS (full): ignored, buffer unchanged.
  - start event in ENTRY: ignored.
  - Timeout counter:
    - Resets to 0 on any event.
    - Otherwise increments each cycle.
    - On reaching TIMEOUT_CYC-1: timeout=1 for one cycle; digits and digit_cnt cleared; go IDLE.
    - An event in that same cycle wins; the timeout does not fire.
- State DONE:
  - digits and amount hold.
  - start event -> ENTRY, buffer cleared, amount retained.
  - Other events ignored.
- A long press produces exactly one event; the level stays high and there is no auto-repeat.
- Reset mid-entry: immediate return to reset values; no amount_valid.
- full = (digit_cnt == DIGITS), combinational from registered count.

Optional Feature:
- Macro CHARGE_BACKSPACE_EN.
- Defined: startSet rising with num == 10 in ENTRY is a backspace event, priority just below enter.
  - Effect: digits <= digits >> 4; digit_cnt-1; counter reset.
  - At digit_cnt==0 it only resets the counter.
- Undefined: num == 10 is ignored like the other non-digit codes.

Decomposition:
- Shared package charge_pkg holds:
  - state enum: IDLE, ENTRY, DONE.
  - key code constants: KEY_DIGIT_MAX=9, KEY_BACKSPACE=10.
  - default DIGITS.
- One natural sub-module: key_edge_det, a parameterised-width rising-edge detector with async active-low reset, instantiated on {startSet, start, clear, enter}.

Test Plan:
- Reset then start, keys 1,2,3, enter -> amount=16'h0123, amount_valid high exactly 1 cycle, state DONE, busy=0.
- Five digits 9,8,7,6,5 with DIGITS=4 -> digits=16'h9876, full=1, fifth key ignored; enter -> amount=16'h9876.
- Keys 4,5, then clear and enter rising in the same cycle -> digits=0, digit_cnt=0, no amount_valid, still ENTRY.
- startSet held 100 cycles with num=7 -> exactly one digit appended.
- Enter in ENTRY with no digits -> no pulse, stays ENTRY.
- TIMEOUT_CYC=50, start, key 3, then idle -> timeout pulse 50 cycles after the key event, state IDLE, digits=0.
- With CHARGE_BACKSPACE_EN: keys 1,2, backspace, 5, enter -> amount=16'h0015.
- RST_n low during ENTRY -> all outputs 0 asynchronously, no valid pulse.

Source files
------------

// File: rtl/charge_pkg.sv
// Shared types and constants for the charge-entry controller slice.
package charge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned KEY_DIGIT_MAX  = 9;
    localparam int unsigned KEY_BACKSPACE  = 10;
    localparam int unsigned DEFAULT_DIGITS = 4;

endpackage

// File: rtl/charge_entry_ctrl_if.sv
// keyMatrix-side inputs and display/balance-side outputs of charge_entry_ctrl.
interface charge_entry_ctrl_if
    import charge_pkg::*;
#(
    parameter int unsigned DIGITS = DEFAULT_DIGITS
);
    localparam int unsigned CW = $clog2(DIGITS + 1);

    logic                  startSet;
    logic [4:0]            num;
    logic                  start;
    logic                  clear;
    logic                  enter;
    logic [4*DIGITS-1:0]   digits;
    logic [CW-1:0]         digit_cnt;
    logic [4*DIGITS-1:0]   amount;
    logic                  amount_valid;
    logic                  busy;
    logic                  full;
    logic                  timeout;

    modport master (
        output startSet, num, start, clear, enter,
        input  digits, digit_cnt, amount, amount_valid, busy, full, timeout
    );

    modport slave (
        input  startSet, num, start, clear, enter,
        output digits, digit_cnt, amount, amount_valid, busy, full, timeout
    );

endinterface

// File: rtl/key_edge_det.sv
// Registered rising-edge detector: a pulse one cycle after each 0->1 input transition.
module key_edge_det #(
    parameter int unsigned W = 1
) (
    input  logic         CLK,
    input  logic         RST_n,
    input  logic [W-1:0] level,
    output logic [W-1:0] rise
);

    logic [W-1:0] level_q;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            level_q <= '0;
            rise    <= '0;
        end else begin
            level_q <= level;
            rise    <= level & ~level_q;
        end
    end

endmodule

// File: rtl/charge_entry_ctrl.sv
// Keypad-to-BCD recharge amount entry controller with idle timeout.
// Optional backspace on key code 10 when CHARGE_BACKSPACE_EN is defined.
module charge_entry_ctrl
    import charge_pkg::*;
#(
    parameter int unsigned DIGITS      = DEFAULT_DIGITS,
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter int unsigned CNT_W       = 20
) (
    input  logic               CLK,
    input  logic               RST_n,
    charge_entry_ctrl_if.slave kb
);

    localparam int unsigned CW = $clog2(DIGITS + 1);

    state_t              state, state_n;
    logic [4*DIGITS-1:0] digits_q, digits_n;
    logic [CW-1:0]       cnt_q, cnt_n;
    logic [4*DIGITS-1:0] amount_q, amount_n;
    logic                valid_q, valid_n;
    logic                tmo_q, tmo_n;
    logic [CNT_W-1:0]    tcnt_q, tcnt_n;

    logic [3:0] ev;
    logic       key_ev, start_ev, clear_ev, enter_ev;
    logic       digit_ev, bksp_ev, any_ev, is_full;

    key_edge_det #(.W(4)) u_edge (
        .CLK   (CLK),
        .RST_n (RST_n),
        .level ({kb.startSet, kb.start, kb.clear, kb.enter}),
        .rise  (ev)
    );

    assign key_ev   = ev[3];
    assign start_ev = ev[2];
    assign clear_ev = ev[1];
    assign enter_ev = ev[0];
    assign digit_ev = key_ev && (kb.num <= 5'(KEY_DIGIT_MAX));
`ifdef CHARGE_BACKSPACE_EN
    assign bksp_ev  = key_ev && (kb.num == 5'(KEY_BACKSPACE));
`else
    assign bksp_ev  = 1'b0;
`endif
    assign any_ev   = digit_ev | bksp_ev | start_ev | clear_ev | enter_ev;
    assign is_full  = (cnt_q == CW'(DIGITS));

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n  = state;
        digits_n = digits_q;
        cnt_n    = cnt_q;
        amount_n = amount_q;
        tcnt_n   = tcnt_q;
        valid_n  = 1'b0;
        tmo_n    = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start_ev) begin
                    state_n  = ENTRY;
                    digits_n = '0;
                    cnt_n    = '0;
                    tcnt_n   = '0;
                end
            end
            ENTRY: begin
                // Any event in the expiry cycle cancels the timeout.
                if (any_ev) begin
                    tcnt_n = '0;
                end else if (tcnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    tcnt_n   = '0;
                    tmo_n    = 1'b1;
                    digits_n = '0;
                    cnt_n    = '0;
                    state_n  = IDLE;
                end else begin
                    tcnt_n = tcnt_q + 1'b1;
                end

                if (clear_ev) begin
                    digits_n = '0;
                    cnt_n    = '0;
                end else if (enter_ev) begin
                    if (cnt_q != '0) begin
                        amount_n = digits_q;
                        valid_n  = 1'b1;
                        state_n  = DONE;
                    end
                end else if (bksp_ev) begin
                    if (cnt_q != '0) begin
                        digits_n = digits_q >> 4;
                        cnt_n    = cnt_q - 1'b1;
                    end
                end else if (digit_ev && !is_full) begin
                    digits_n = {digits_q[4*DIGITS-5:0], kb.num[3:0]};
                    cnt_n    = cnt_q + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            digits_q <= '0;
            cnt_q    <= '0;
            amount_q <= '0;
            valid_q  <= 1'b0;
            tmo_q    <= 1'b0;
            tcnt_q   <= '0;
        end else begin
            digits_q <= digits_n;
            cnt_q    <= cnt_n;
            amount_q <= amount_n;
            valid_q  <= valid_n;
            tmo_q    <= tmo_n;
            tcnt_q   <= tcnt_n;
        end
    end

    always_comb begin
        kb.digits       = digits_q;
        kb.digit_cnt    = cnt_q;
        kb.amount       = amount_q;
        kb.amount_valid = valid_q;
        kb.timeout      = tmo_q;
        kb.busy         = (state == ENTRY);
        kb.full         = is_full;
    end

endmodule

// File: tb/tb_charge_entry_ctrl.sv
// Scoreboard bench: expected amounts queued on enter, popped on amount_valid.
module tb_charge_entry_ctrl;

    localparam int SEL_START = 0;
    localparam int SEL_CLEAR = 1;
    localparam int SEL_ENTER = 2;

    logic       CLK = 1'b0;
    logic       RST_n = 1'b0;
    logic       startSet = 1'b0;
    logic [4:0] num = '0;
    logic       start = 1'b0;
    logic       clear = 1'b0;
    logic       enter = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_e;

    always #5 CLK = ~CLK;

    charge_entry_ctrl_if #(.DIGITS(4)) ifa ();
    charge_entry_ctrl_if #(.DIGITS(4)) ifb ();

    assign ifa.startSet = startSet;
    assign ifa.num      = num;
    assign ifa.start    = start;
    assign ifa.clear    = clear;
    assign ifa.enter    = enter;
    assign ifb.startSet = startSet;
    assign ifb.num      = num;
    assign ifb.start    = start;
    assign ifb.clear    = clear;
    assign ifb.enter    = enter;

    charge_entry_ctrl #(.DIGITS(4), .TIMEOUT_CYC(1000), .CNT_W(10)) dut (
        .CLK   (CLK),
        .RST_n (RST_n),
        .kb    (ifa)
    );

    charge_entry_ctrl #(.DIGITS(4), .TIMEOUT_CYC(50), .CNT_W(6)) dut_to (
        .CLK   (CLK),
        .RST_n (RST_n),
        .kb    (ifb)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge CLK) begin
        #1;
        if (ifa.amount_valid) begin
            if (exp_q.size() == 0) begin
                check("valid_unexpected", ifa.amount_valid, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("amount", ifa.amount, mon_e);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic press(input logic [4:0] k);
        startSet = 1'b1;
        num      = k;
        step(1);
        startSet = 1'b0;
        step(2);
    endtask

    task automatic pulse(input int sel);
        case (sel)
            SEL_START: start = 1'b1;
            SEL_CLEAR: clear = 1'b1;
            default:   enter = 1'b1;
        endcase
        step(1);
        start = 1'b0;
        clear = 1'b0;
        enter = 1'b0;
        step(2);
    endtask

    task automatic do_enter(input logic [15:0] e);
        exp_q.push_back(e);
        pulse(SEL_ENTER);
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) step(1);
        check("valid_seen", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_n = 1'b0;
        step(2);
        RST_n = 1'b1;
        step(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int  cyc;
        bit  found;

        do_reset();
        check("rst_digits", ifa.digits, 0);
        check("rst_cnt", ifa.digit_cnt, 0);
        check("rst_amount", ifa.amount, 0);
        check("rst_valid", ifa.amount_valid, 0);
        check("rst_busy", ifa.busy, 0);
        check("rst_full", ifa.full, 0);
        check("rst_timeout", ifa.timeout, 0);

        press(5'd5);
        check("idle_digit_ignored", ifa.digit_cnt, 0);
        check("idle_busy", ifa.busy, 0);

        pulse(SEL_START);
        check("start_busy", ifa.busy, 1);
        press(5'd1); press(5'd2); press(5'd3);
        check("d123_digits", ifa.digits, 16'h0123);
        check("d123_cnt", ifa.digit_cnt, 3);
        do_enter(16'h0123);
        check("done_busy", ifa.busy, 0);
        check("done_amount", ifa.amount, 16'h0123);
        check("done_digits_hold", ifa.digits, 16'h0123);

        pulse(SEL_START);
        check("restart_busy", ifa.busy, 1);
        check("restart_digits", ifa.digits, 0);
        check("restart_cnt", ifa.digit_cnt, 0);
        check("restart_amount_kept", ifa.amount, 16'h0123);
        press(5'd9); press(5'd8); press(5'd7); press(5'd6);
        check("full_flag", ifa.full, 1);
        press(5'd5);
        check("full_digits", ifa.digits, 16'h9876);
        check("full_cnt", ifa.digit_cnt, 4);
        pulse(SEL_START);
        check("entry_start_ignored", ifa.digits, 16'h9876);
        do_enter(16'h9876);

        pulse(SEL_START);
        press(5'd4); press(5'd5);
        check("d45_digits", ifa.digits, 16'h0045);
        clear = 1'b1;
        enter = 1'b1;
        step(1);
        clear = 1'b0;
        enter = 1'b0;
        step(2);
        check("clr_enter_digits", ifa.digits, 0);
        check("clr_enter_cnt", ifa.digit_cnt, 0);
        check("clr_enter_busy", ifa.busy, 1);

        pulse(SEL_ENTER);
        check("empty_enter_busy", ifa.busy, 1);
        check("empty_enter_amount", ifa.amount, 16'h9876);

        startSet = 1'b1;
        num      = 5'd7;
        step(100);
        startSet = 1'b0;
        step(2);
        check("long_press_digits", ifa.digits, 16'h0007);
        check("long_press_cnt", ifa.digit_cnt, 1);

        pulse(SEL_CLEAR);
        press(5'd1); press(5'd2); press(5'd10); press(5'd5);
`ifdef CHARGE_BACKSPACE_EN
        check("bksp_digits", ifa.digits, 16'h0015);
        do_enter(16'h0015);
`else
        check("code10_ignored", ifa.digits, 16'h0125);
        do_enter(16'h0125);
`endif

        pulse(SEL_START);
        press(5'd4);
        check("pre_rst_cnt", ifa.digit_cnt, 1);
        RST_n = 1'b0;
        #1;
        check("arst_digits", ifa.digits, 0);
        check("arst_cnt", ifa.digit_cnt, 0);
        check("arst_amount", ifa.amount, 0);
        check("arst_busy", ifa.busy, 0);
        check("arst_valid", ifa.amount_valid, 0);
        step(2);
        RST_n = 1'b1;
        step(1);

        pulse(SEL_START);
        check("to_busy", ifb.busy, 1);
        step(2);
        startSet = 1'b1;
        num      = 5'd3;
        found    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            if (ifb.digit_cnt == 1) begin
                found = 1'b1;
                break;
            end
        end
        check("to_key_seen", found, 1);
        startSet = 1'b0;
        cyc   = 0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge CLK); #1;
            cyc++;
            if (ifb.timeout) begin
                found = 1'b1;
                break;
            end
        end
        check("to_fired", found, 1);
        check("to_cycles", cyc, 50);
        check("to_busy_after", ifb.busy, 0);
        check("to_digits_after", ifb.digits, 0);
        check("to_cnt_after", ifb.digit_cnt, 0);
        @(posedge CLK); #1;
        check("to_one_cycle", ifb.timeout, 0);

        step(3);
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
